mem_port_arbiter: RTL and testbench

//  Shares one single-port memory between IF-stage instruction fetch and MEM-stage

---
 rtl/mem_port_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and data load/store, with a starvation guard for fetches and a timeout path.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   i_if_req/addr/abort   fetch request, PC, squash of pending/in-flight fetch
//   o_if_ack/rdata        fetch completion pulse and instruction word
//   i_dm_req/we/addr/wdata data request (store when we=1)
//   o_dm_ack/rdata        data completion pulse and load data
//   o_mem_req/we/addr/wdata  registered request to the memory, held until ack
//   i_mem_rdata/ack       memory read data and one-cycle completion
//   o_stall_if/stall_mem  combinational pipeline freeze signals
//   o_err                 sticky timeout flag
module mem_port_arbiter #(
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT         = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    input  logic        i_if_abort,
    output logic        o_if_ack,
    output logic [31:0] o_if_rdata,
    input  logic        i_dm_req,
    input  logic        i_dm_we,
    input  logic [31:0] i_dm_addr,
    input  logic [31:0] i_dm_wdata,
    output logic        o_dm_ack,
    output logic [31:0] o_dm_rdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack,
    output logic        o_stall_if,
    output logic        o_stall_mem,
    output logic        o_err
);

    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [31:0]   DEAD_WORD  = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY_I,
        S_BUSY_D,
        S_ACK
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_streak;
    logic [TW-1:0]   r_timer;
    logic            r_squash;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [31:0]     r_mem_addr;
    logic [31:0]     r_mem_wdata;
    logic            r_if_ack;
    logic [31:0]     r_if_rdata;
    logic            r_dm_ack;
    logic [31:0]     r_dm_rdata;
    logic            r_err;

    logic            w_if_elig;
    logic            w_pick_if;
    logic            w_pick_dm;
    logic            w_timeout;
    logic            w_squash;

    // A fetch under abort is never eligible; once the data streak is
    // exhausted a waiting fetch overrides data priority.
    assign w_if_elig = i_if_req & ~i_if_abort;
    assign w_pick_if = w_if_elig & (~i_dm_req | (r_streak == STREAK_MAX));
    assign w_pick_dm = i_dm_req & ~w_pick_if;
    assign w_timeout = (r_timer == TIMER_LAST);
    // Abort on the completing cycle squashes the fetch as well.
    assign w_squash  = r_squash | i_if_abort;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_streak    <= '0;
            r_timer     <= '0;
            r_squash    <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ack    <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_ack    <= 1'b0;
            r_dm_rdata  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_timer  <= '0;
                    r_squash <= 1'b0;
                    if (w_pick_if) begin
                        r_state     <= S_BUSY_I;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= i_if_addr;
                        r_mem_wdata <= '0;
                        r_streak    <= '0;
                    end else if (w_pick_dm) begin
                        r_state     <= S_BUSY_D;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= i_dm_we;
                        r_mem_addr  <= i_dm_addr;
                        r_mem_wdata <= i_dm_wdata;
                        if (!i_if_req)
                            r_streak <= '0;
                        else if (r_streak != STREAK_MAX)
                            r_streak <= r_streak + 1'b1;
                    end
                end
                S_BUSY_I: begin
                    if (i_if_abort)
                        r_squash <= 1'b1;
                    if (i_mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_ACK;
                        if (!w_squash) begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= i_mem_rdata;
                        end
                    end else if (w_timeout) begin
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= S_ACK;
                        if (!w_squash) begin
                            r_if_ack   <= 1'b1;
                            r_if_rdata <= DEAD_WORD;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_BUSY_D: begin
                    if (i_mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_ACK;
                        r_dm_ack  <= 1'b1;
                        if (!r_mem_we)
                            r_dm_rdata <= i_mem_rdata;
                    end else if (w_timeout) begin
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= S_ACK;
                        r_dm_ack  <= 1'b1;
                        if (!r_mem_we)
                            r_dm_rdata <= DEAD_WORD;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_if_ack    = r_if_ack;
    assign o_if_rdata  = r_if_rdata;
    assign o_dm_ack    = r_dm_ack;
    assign o_dm_rdata  = r_dm_rdata;
    assign o_err       = r_err;

    assign o_stall_if  = i_if_req & ~r_if_ack & ~i_if_abort;
    assign o_stall_mem = i_dm_req & ~r_dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with a
// variable-latency memory responder.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_if_req, i_if_abort;
    logic [31:0] i_if_addr;
    logic        o_if_ack;
    logic [31:0] o_if_rdata;
    logic        i_dm_req, i_dm_we;
    logic [31:0] i_dm_addr, i_dm_wdata;
    logic        o_dm_ack;
    logic [31:0] o_dm_rdata;
    logic        o_mem_req, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        i_mem_ack;
    logic        o_stall_if, o_stall_mem, o_err;

    int n_checks = 0;
    int n_errors = 0;
    int lat = 1;
    int mcnt = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(
        .MAX_DATA_STREAK(4),
        .TIMEOUT(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .i_if_req(i_if_req),
        .i_if_addr(i_if_addr),
        .i_if_abort(i_if_abort),
        .o_if_ack(o_if_ack),
        .o_if_rdata(o_if_rdata),
        .i_dm_req(i_dm_req),
        .i_dm_we(i_dm_we),
        .i_dm_addr(i_dm_addr),
        .i_dm_wdata(i_dm_wdata),
        .o_dm_ack(o_dm_ack),
        .o_dm_rdata(o_dm_rdata),
        .o_mem_req(o_mem_req),
        .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata),
        .i_mem_ack(i_mem_ack),
        .o_stall_if(o_stall_if),
        .o_stall_mem(o_stall_mem),
        .o_err(o_err)
    );

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'h5A5A1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Memory: acks the lat-th cycle that mem_req is seen high; lat=0 never acks.
    initial begin
        i_mem_ack   = 1'b0;
        i_mem_rdata = '0;
        forever begin
            @(posedge clock);
            #1;
            i_mem_ack = 1'b0;
            if (o_mem_req) begin
                mcnt++;
                if (lat != 0 && mcnt >= lat) begin
                    i_mem_ack   = 1'b1;
                    i_mem_rdata = mdata(o_mem_addr);
                    mcnt        = 0;
                end
            end else begin
                mcnt = 0;
            end
        end
    end

    initial begin
        logic [31:0] grants[$];
        logic [31:0] exp_g[6];
        logic        prev;
        logic        seen;

        reset = 1'b1;
        i_if_req = 0; i_if_addr = 0; i_if_abort = 0;
        i_dm_req = 0; i_dm_we = 0; i_dm_addr = 0; i_dm_wdata = 0;
        tick();
        tick();
        chk("rst_mem_req", {31'd0, o_mem_req}, 0);
        chk("rst_if_ack", {31'd0, o_if_ack}, 0);
        chk("rst_dm_ack", {31'd0, o_dm_ack}, 0);
        chk("rst_err", {31'd0, o_err}, 0);
        chk("rst_mem_addr", o_mem_addr, 0);
        reset = 1'b0;
        tick();

        // Fetch only, minimum latency, back-to-back.
        i_if_req = 1; i_if_addr = 32'h0;
        tick();
        chk("f_mem_req", {31'd0, o_mem_req}, 1);
        chk("f_mem_addr", o_mem_addr, 32'h0);
        chk("f_mem_we", {31'd0, o_mem_we}, 0);
        chk("f_stall_if", {31'd0, o_stall_if}, 1);
        tick();
        chk("f_if_ack", {31'd0, o_if_ack}, 1);
        chk("f_if_rdata", o_if_rdata, mdata(32'h0));
        chk("f_stall_if_ack", {31'd0, o_stall_if}, 0);
        chk("f_mem_req_drop", {31'd0, o_mem_req}, 0);
        i_if_addr = 32'h4;
        tick();
        chk("f_ack_pulse", {31'd0, o_if_ack}, 0);
        chk("f_no_grant_ack", {31'd0, o_mem_req}, 0);
        tick();
        chk("f2_mem_req", {31'd0, o_mem_req}, 1);
        chk("f2_mem_addr", o_mem_addr, 32'h4);
        tick();
        chk("f2_if_ack", {31'd0, o_if_ack}, 1);
        chk("f2_if_rdata", o_if_rdata, mdata(32'h4));
        i_if_req = 0;
        tick();
        tick();

        // Starvation guard: four data grants, then the fetch.
        i_if_req = 1; i_if_addr = 32'h100;
        i_dm_req = 1; i_dm_we = 0; i_dm_addr = 32'h40;
        prev = 1'b0;
        for (int c = 0; c < 60 && grants.size() < 6; c++) begin
            tick();
            if (o_mem_req && !prev)
                grants.push_back(o_mem_addr);
            prev = o_mem_req;
        end
        i_if_req = 0;
        i_dm_req = 0;
        chk("arb_ngrants", grants.size(), 6);
        exp_g = '{32'h40, 32'h40, 32'h40, 32'h40, 32'h100, 32'h40};
        for (int i = 0; i < 6; i++)
            if (i < grants.size())
                chk($sformatf("arb_grant%0d", i), grants[i], exp_g[i]);
        tick();
        chk("arb_dm_ack", {31'd0, o_dm_ack}, 1);
        chk("arb_dm_rdata", o_dm_rdata, mdata(32'h40));
        chk("arb_if_rdata", o_if_rdata, mdata(32'h100));
        tick();
        tick();

        // Store: dm_rdata keeps the previous load value.
        i_dm_req = 1; i_dm_we = 1;
        i_dm_addr = 32'h10; i_dm_wdata = 32'hCAFEF00D;
        tick();
        chk("st_mem_we", {31'd0, o_mem_we}, 1);
        chk("st_mem_addr", o_mem_addr, 32'h10);
        chk("st_mem_wdata", o_mem_wdata, 32'hCAFEF00D);
        chk("st_stall_mem", {31'd0, o_stall_mem}, 1);
        tick();
        chk("st_dm_ack", {31'd0, o_dm_ack}, 1);
        chk("st_dm_rdata", o_dm_rdata, mdata(32'h40));
        chk("st_stall_mem_ack", {31'd0, o_stall_mem}, 0);
        i_dm_req = 0; i_dm_we = 0;
        tick();
        tick();

        // Squashed fetch, memory latency 3.
        lat = 3;
        i_if_req = 1; i_if_addr = 32'h200;
        tick();
        chk("ab_mem_req", {31'd0, o_mem_req}, 1);
        chk("ab_mem_wdata", o_mem_wdata, 32'h0);
        i_if_abort = 1;
        #1;
        chk("ab_stall_if", {31'd0, o_stall_if}, 0);
        tick();
        i_if_abort = 0;
        i_if_req = 0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (o_if_ack)
                seen = 1'b1;
        end
        chk("ab_no_ack", {31'd0, seen}, 0);
        chk("ab_if_rdata", o_if_rdata, mdata(32'h100));
        chk("ab_idle", {31'd0, o_mem_req}, 0);

        // Timeout: memory never acks.
        lat = 0;
        i_dm_req = 1; i_dm_we = 0; i_dm_addr = 32'h80;
        tick();
        chk("to_mem_req1", {31'd0, o_mem_req}, 1);
        repeat (7) tick();
        chk("to_mem_req8", {31'd0, o_mem_req}, 1);
        chk("to_err_pre", {31'd0, o_err}, 0);
        chk("to_ack_pre", {31'd0, o_dm_ack}, 0);
        tick();
        chk("to_mem_req9", {31'd0, o_mem_req}, 0);
        chk("to_err", {31'd0, o_err}, 1);
        chk("to_dm_ack", {31'd0, o_dm_ack}, 1);
        chk("to_dm_rdata", o_dm_rdata, 32'hDEADBEEF);
        i_dm_req = 0;
        lat = 1;
        i_if_req = 1; i_if_addr = 32'h300;
        for (int c = 0; c < 10 && !o_if_ack; c++)
            tick();
        chk("to_next_ack", {31'd0, o_if_ack}, 1);
        chk("to_next_rdata", o_if_rdata, mdata(32'h300));
        chk("to_err_sticky", {31'd0, o_err}, 1);
        i_if_req = 0;
        tick();
        tick();

        // Reset in the middle of a data access.
        lat = 0;
        i_dm_req = 1; i_dm_we = 0; i_dm_addr = 32'h44;
        tick();
        chk("rb_mem_req", {31'd0, o_mem_req}, 1);
        reset = 1;
        i_dm_req = 0;
        tick();
        chk("rb_mem_req0", {31'd0, o_mem_req}, 0);
        chk("rb_mem_addr", o_mem_addr, 0);
        chk("rb_dm_ack", {31'd0, o_dm_ack}, 0);
        chk("rb_dm_rdata", o_dm_rdata, 0);
        chk("rb_if_rdata", o_if_rdata, 0);
        chk("rb_err", {31'd0, o_err}, 0);
        reset = 0;
        lat = 1;
        tick();
        chk("rb_no_ack", {31'd0, o_dm_ack}, 0);
        i_if_req = 1; i_if_addr = 32'h8;
        tick();
        chk("rb_idle_grant", {31'd0, o_mem_req}, 1);
        tick();
        chk("rb_if_ack", {31'd0, o_if_ack}, 1);
        chk("rb_if_rdata", o_if_rdata, mdata(32'h8));
        i_if_req = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
